// File: rtl/t08_mem_pkg.sv
// t08_mem_pkg: shared types and helpers for the team_08 memory handler.
//   state_t      - handler FSM states (IDLE, REQ, DONE)
//   F3_*         - funct3 encodings of the supported load/store sizes
//   access_legal - size/alignment legality check for a request
//   lane_sel     - byte enables for an access
//   lane_wdata   - store data replicated across the byte lanes
package t08_mem_pkg;

    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: return 1'b1;
            F3_H, F3_HU: return ~a[0];
            F3_W:        return (a == 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // funct3[1:0] encodes the size; only legal codes ever reach these helpers.
    function automatic logic [NUM_LANES-1:0] lane_sel(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/t08_load_extend.sv
// t08_load_extend: picks the addressed byte/half out of a bus word and
// sign- or zero-extends it according to funct3.
//   rdata  in  32 - raw bus read word
//   addr   in  2  - byte offset within the word
//   funct3 in  3  - access size/sign
//   result out 32 - extended load value
module t08_load_extend
    import t08_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [NUM_LANES-1:0][VEC_W-1:0] lanes;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign lanes  = rdata;
    assign byte_v = lanes[addr];
    // Halves are 2-byte aligned, so only addr[1] picks the half.
    assign half_v = addr[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{24{byte_v[7]}}, byte_v};
            F3_H:    result = {{16{half_v[15]}}, half_v};
            F3_BU:   result = {24'd0, byte_v};
            F3_HU:   result = {16'd0, half_v};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/t08_mem_handler.sv
// t08_mem_handler: memory-side counterpart of the team_08 decoder. Runs one
// single-beat bus transaction per load/store with lane steering, byte
// enables and load extension, stalling fetch until the access completes.
//   clk, reset         - clock (rising), async active-low reset
//   read, write        - decoder load/store request (write wins if both)
//   funct3, address    - access size/sign and byte address
//   store_data         - rs2 value for stores
//   load_data          - extended load result, held until the next load
//   done, misaligned   - one-cycle completion / illegal-access pulses
//   stall              - hold PC/fetch (combinational)
//   bus_*              - single-beat data bus (strobes held until bus_ack)
//   timeout_err        - one-cycle pulse when the bus wait limit expires
// Optional feature: define T08_MEM_TIMEOUT_EN to enable the REQ wait limit of
// TIMEOUT_CYCLES cycles; otherwise REQ waits forever and timeout_err is 0.
module t08_mem_handler
    import t08_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        done,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        timeout_err
);

    state_t      state;
    logic [1:0]  addr_lo_q;
    logic [2:0]  f3_q;
    logic        req;
    logic        legal;
    logic [31:0] ext_data;

    assign req   = read | write;
    assign legal = access_legal(funct3, address[1:0]);
    assign stall = (state == REQ) || ((state == IDLE) && req && legal);

    t08_load_extend u_ext (
        .rdata  (bus_rdata),
        .addr   (addr_lo_q),
        .funct3 (f3_q),
        .result (ext_data)
    );

`ifdef T08_MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_q;
    assign timeout_err = tmo_q;
`else
    // The limit only matters when the counter is built; the term folds to 0.
    assign timeout_err = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            load_data  <= '0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_read   <= 1'b0;
            bus_write  <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_sel    <= '0;
            addr_lo_q  <= '0;
            f3_q       <= '0;
`ifdef T08_MEM_TIMEOUT_EN
            tmo_cnt    <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
`ifdef T08_MEM_TIMEOUT_EN
            tmo_q      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        if (legal) begin
                            state     <= REQ;
                            bus_write <= write;
                            bus_read  <= ~write;
                            bus_addr  <= {address[31:2], 2'b00};
                            bus_sel   <= lane_sel(funct3, address[1:0]);
                            bus_wdata <= lane_wdata(funct3, store_data);
                            addr_lo_q <= address[1:0];
                            f3_q      <= funct3;
`ifdef T08_MEM_TIMEOUT_EN
                            tmo_cnt   <= '0;
`endif
                        end else begin
                            misaligned <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        // bus_read still reflects the latched direction here.
                        if (bus_read)
                            load_data <= ext_data;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
`ifdef T08_MEM_TIMEOUT_EN
                    else if (tmo_cnt == CNT_LAST) begin
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        done      <= 1'b1;
                        tmo_q     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                // Requests are ignored here so the same instruction is not re-issued.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t08_mem_handler.sv
module tb_t08_mem_handler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read = 1'b0, write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] address = '0, store_data = '0;
    logic [31:0] load_data;
    logic        done, stall, misaligned;
    logic        bus_read, bus_write;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ld_model = '0;

    t08_mem_handler #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .read(read), .write(write), .funct3(funct3),
        .address(address), .store_data(store_data), .load_data(load_data),
        .done(done), .stall(stall), .misaligned(misaligned),
        .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load: shift the addressed lane down, then extend.
    function automatic logic [31:0] model_ld(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [31:0] s;
        s = d >> (int'(a) * 8);
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'd0, s[7:0]};
            3'b101:  return {16'd0, s[15:0]};
            default: return d;
        endcase
    endfunction

    // Called at a negedge: presents a request, waits dly cycles, acks.
    task automatic run_access(input string nm, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rdat,
                              input int dly, input logic [3:0] esel,
                              input logic [31:0] ewd);
        read = rd; write = wr; funct3 = f3; address = a; store_data = sd;
        if (!wr) ld_model = model_ld(f3, a[1:0], rdat);
        exp_q.push_back(ld_model);
        #1 chk({nm, "_stall_req"}, stall, 1);
        @(negedge clk);
        read = 0; write = 0;
        chk({nm, "_bus_read"}, bus_read, rd & ~wr);
        chk({nm, "_bus_write"}, bus_write, wr);
        chk({nm, "_bus_addr"}, bus_addr, {a[31:2], 2'b00});
        chk({nm, "_bus_sel"}, bus_sel, esel);
        if (wr) chk({nm, "_bus_wdata"}, bus_wdata, ewd);
        chk({nm, "_stall_busy"}, stall, 1);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk({nm, "_strobe_hold"}, bus_read | bus_write, 1);
            chk({nm, "_no_done"}, done, 0);
        end
        bus_ack = 1; bus_rdata = rdat;
        @(negedge clk);
        bus_ack = 0; bus_rdata = $urandom;
        chk({nm, "_done"}, done, 1);
        chk({nm, "_stall_done"}, stall, 0);
        chk({nm, "_strobe_off"}, bus_read | bus_write, 0);
        chk({nm, "_load_data"}, load_data, exp_q.pop_front());
        @(negedge clk);
        chk({nm, "_done_pulse"}, done, 0);
    endtask

    initial begin
        #1 chk("rst_load_data", load_data, 0);
        chk("rst_flags", {done, misaligned, bus_read, bus_write, timeout_err}, 0);
        chk("rst_bus", {bus_addr ^ bus_wdata, 28'd0, bus_sel}, 0);
        @(negedge clk); @(negedge clk);
        reset = 1;
        @(negedge clk);

        run_access("lw",  1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 4'b1111, 0);
        run_access("lb",  1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 0, 4'b1000, 0);
        run_access("lbu", 1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 1, 4'b1000, 0);
        run_access("sh",  0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 0, 4'b1100, 32'hABCDABCD);
        run_access("lh",  1, 0, 3'b001, 32'h202, 0, 32'h8001_7FFF, 2, 4'b1100, 0);
        run_access("lhu", 1, 0, 3'b101, 32'h200, 0, 32'h1234_F00D, 0, 4'b0011, 0);
        run_access("rw_both", 1, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 0, 4'b1111, 32'hCAFEF00D);

        // Illegal accesses: misaligned word, then reserved funct3.
        read = 1; funct3 = 3'b010; address = 32'h101;
        #1 chk("mis_stall", stall, 0);
        @(negedge clk);
        read = 0;
        chk("mis_pulse", misaligned, 1);
        chk("mis_no_bus", bus_read | bus_write, 0);
        chk("mis_no_done", done, 0);
        @(negedge clk);
        chk("mis_clear", misaligned, 0);
        chk("mis_no_bus2", bus_read, 0);
        chk("mis_ld_keep", load_data, ld_model);
        read = 1; funct3 = 3'b011; address = 32'h100;
        #1 chk("f3_stall", stall, 0);
        @(negedge clk);
        read = 0;
        chk("f3_pulse", misaligned, 1);
        chk("f3_no_bus", bus_read, 0);
        @(negedge clk);
        chk("f3_clear", misaligned, 0);

        // Stray ack in IDLE must not complete anything.
        bus_ack = 1;
        @(negedge clk);
        bus_ack = 0;
        chk("stray_ack_done", done, 0);
        chk("stray_ack_ld", load_data, ld_model);

`ifdef T08_MEM_TIMEOUT_EN
        read = 1; funct3 = 3'b010; address = 32'h400;
        @(negedge clk);
        read = 0;
        for (int i = 0; i < 4; i++) begin
            chk("tmo_strobe_hold", bus_read, 1);
            @(negedge clk);
        end
        chk("tmo_strobe_off", bus_read, 0);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_done", done, 1);
        chk("tmo_ld_keep", load_data, ld_model);
        @(negedge clk);
        chk("tmo_err_pulse", timeout_err, 0);
`endif

        // Reset during a long REQ: strobes drop immediately.
        read = 1; funct3 = 3'b010; address = 32'h500;
        @(negedge clk);
        read = 0;
        chk("rreq_strobe", bus_read, 1);
        @(negedge clk); @(negedge clk);
        #2 reset = 0;
        #1 chk("rreq_async_drop", bus_read, 0);
        chk("rreq_stall", stall, 0);
        chk("rreq_done", done, 0);
        ld_model = '0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        run_access("sb", 0, 1, 3'b000, 32'h101, 32'h00000055, 32'h0, 0, 4'b0010, 32'h55555555);

        chk("sb_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/t08_mem_handler.md
Name: t08_mem_handler

Overview:
Memory-side counterpart of the team_08 instruction decoder. It consumes the decoder's read, write and funct3 together with the ALU-computed address and the rs2 store data. It then runs one single-beat transaction on the data bus, performing byte-lane steering, write strobes, and load sign/zero extension. It stalls fetch until the access completes and returns load data to the register file.

Parameters:
- TIMEOUT_CYCLES, 255: bus wait limit in cycles; used only when T08_MEM_TIMEOUT_EN is defined.

Ports:
- clk in 1: system clock, rising edge.
- reset in 1: reset, asynchronous, active-low.
- read in 1: load request from the decoder.
- write in 1: store request from the decoder.
- funct3 in 3: access size and sign. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- address in 32: byte address from the ALU.
- store_data in 32: rs2 value.
- load_data out 32: extended load result to the register file.
- done out 1: one-cycle completion pulse.
- stall out 1: hold PC/fetch.
- misaligned out 1: one-cycle pulse on a misaligned access or illegal funct3.
- bus_read out 1: bus read strobe.
- bus_write out 1: bus write strobe.
- bus_addr out 32: word address, with {address[31:2], 2'b00}.
- bus_wdata out 32: lane-replicated store data.
- bus_sel out 4: byte enables.
- bus_rdata in 32: read data, valid with bus_ack.
- bus_ack in 1: completion from memory.
- timeout_err out 1: one-cycle pulse; drives 0 when the feature is compiled out.

Behaviour:
- Reset: all outputs are 0, state = IDLE. Assertion mid-transaction aborts immediately and drops the bus strobes asynchronously. No done pulse is produced.
- States: IDLE, REQ, DONE.
- IDLE:
  - If read or write is high and the access is legal, latch address, funct3, store_data and the direction, then go to REQ.
  - If both read and write are high, write wins.
  - If the access is illegal, pulse misaligned next cycle, stay in IDLE, and issue no bus access. load_data is unchanged.
- Legality:
  - H/HU requires address[0] == 0.
  - W requires address[1:0] == 0.
  - funct3 values 011, 110 and 111 are illegal.
- REQ:
  - bus_read or bus_write is held high, with bus_addr, bus_sel and bus_wdata stable, until the cycle bus_ack is high.
  - On ack, register the extended load data and go to DONE. Ack is the earliest completion point; minimum REQ dwell is 1 cycle.
  - bus_ack outside REQ is ignored.
- DONE:
  - done = 1 and load_data is valid; go to IDLE.
  - read and write are ignored in DONE, so the same instruction is not re-issued.
- Minimum latency: request in cycle N, bus strobe in N+1, done in N+2 when ack arrives in N+1.
- stall (combinational):
  - High in REQ.
  - High in IDLE when a legal read or write is presented.
  - Low in DONE and otherwise.
  - The PC advances on the edge that leaves DONE.
- bus_sel:
  - B: 4'b0001 << address[1:0].
  - H: 4'b0011 << {address[1], 1'b0}.
  - W: 4'b1111.
- bus_wdata:
  - B: store byte replicated ×4.
  - H: store half replicated ×2.
  - W: as is.
- Loads:
  - Select the lane per the latched address[1:0].
  - B/H are sign-extended from bit 7/15.
  - BU/HU are zero-extended.
  - W is passed through.
- load_data holds its value until the next completed load; stores do not modify it.

Optional Feature:
- Macro T08_MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter runs while in REQ.
  - If TIMEOUT_CYCLES cycles elapse without ack, drop the strobes, pulse timeout_err and done together, leave load_data unchanged, and return to IDLE through DONE.
  - The counter clears on entry to REQ.
- Undefined: no counter, REQ waits indefinitely, and timeout_err is tied to 0.

Decomposition:
- Package t08_mem_pkg:
  - State enum (IDLE, REQ, DONE).
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module t08_load_extend:
  - Combinational lane select plus sign/zero extension.
  - Inputs: rdata, addr[1:0], funct3.
  - Output: 32-bit result.
  - Instantiated once.

Test Plan:
- LW at 0x100, ack in the first REQ cycle with rdata = 0xDEADBEEF -> bus_addr = 0x100, sel = 1111, done in N+2, load_data = 0xDEADBEEF, stall high for 2 cycles.
- LB at 0x103 with rdata = 0x80FF_0000 -> sel = 1000, load_data = 0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at 0x102 with store_data = 0x1234ABCD -> bus_write = 1, sel = 1100, wdata = 0xABCDABCD, load_data unchanged.
- LW at 0x101 -> misaligned pulse, no bus_read ever asserted, stall 0, no done; funct3 = 011 behaves the same.
- Ack delayed 5 cycles, then reset asserted during REQ -> strobes drop immediately and state is IDLE; after release, a new SB completes normally.
- With T08_MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4 and no ack -> strobe drops after 4 cycles, timeout_err and done pulse, load_data unchanged.
